// File: rtl/fft_peak_detect.sv
// Streaming spectral peak detector: squares each complex FFT bin, tracks the
// argmax over a frame of NBINS bins arriving LANES bins per beat, and reports
// bin index, magnitude and an above-threshold flag two cycles after the last
// beat. Counts completed frames and halts after MAX_FRAMES (0 = never).
module fft_peak_detect #(
    parameter int W          = 16,
    parameter int NBINS      = 16,
    parameter int LANES      = 4,
    parameter int MAX_FRAMES = 64,
    parameter int CNT_W      = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fft_valid,
    output logic                      fft_ready,
    input  logic [LANES*2*W-1:0]      fft_data,
    input  logic [2*W-1:0]            thresh,
    output logic                      done,
    output logic [$clog2(NBINS)-1:0]  freq,
    output logic [2*W-1:0]            peak_mag,
    output logic                      above,
    output logic [CNT_W-1:0]          frame_cnt,
    output logic                      halted
);

    localparam int MW     = 2 * W;
    localparam int NBEATS = NBINS / LANES;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int FW     = $clog2(NBINS);
    localparam int LVLS   = $clog2(LANES);
    localparam int LW     = (LANES > 1) ? LVLS : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_FRAMES);

    // |X|^2 of one lane word {re, im}; the worst case 2^(2W-1) fits unsigned
    function automatic logic [MW-1:0] mag_sq(input logic [MW-1:0] lane);
        logic signed [MW-1:0] re;
        logic signed [MW-1:0] im;
        logic signed [MW-1:0] re_sq;
        logic signed [MW-1:0] im_sq;
        re    = {{W{lane[MW-1]}}, lane[MW-1:W]};
        im    = {{W{lane[W-1]}}, lane[W-1:0]};
        re_sq = re * re;
        im_sq = im * im;
        return $unsigned(re_sq) + $unsigned(im_sq);
    endfunction

    logic [BW-1:0]   r_beat;
    logic            r_vld_p1;
    logic            r_first_p1;
    logic            r_last_p1;
    logic [BW-1:0]   r_beat_p1;
    logic [MW-1:0]   r_thresh_p1;
    logic [MW-1:0]   r_mag_p1 [LANES];

    logic [MW-1:0]   r_run_mag_p2;
    logic [FW-1:0]   r_run_bin_p2;
    logic            r_done;
    logic [FW-1:0]   r_freq;
    logic [MW-1:0]   r_peak;
    logic            r_above;
    logic [CNT_W-1:0] r_cnt;
    logic            r_halted;

    logic            w_accept;
    logic            w_first;
    logic            w_last;
    logic [MW-1:0]   w_tm [0:LVLS][0:LANES-1];
    logic [LW-1:0]   w_ti [0:LVLS][0:LANES-1];
    logic [MW-1:0]   w_beat_max;
    logic [FW-1:0]   w_beat_bin;
    logic            w_take;
    logic [MW-1:0]   w_new_mag;
    logic [FW-1:0]   w_new_bin;
    logic            w_fin;

    assign fft_ready = !r_halted;
    assign w_accept  = fft_valid && !r_halted;
    assign w_first   = (r_beat == '0);
    assign w_last    = (r_beat == BW'(NBEATS - 1));

    // ---- stage 1: per-lane magnitude, beat position ----

    // Beat counter and stage-1 control; reset discards any partial frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat     <= '0;
            r_vld_p1   <= 1'b0;
            r_first_p1 <= 1'b0;
            r_last_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= w_accept;
            if (w_accept) begin
                r_beat     <= w_last ? '0 : r_beat + 1'b1;
                r_first_p1 <= w_first;
                r_last_p1  <= w_last;
            end
        end
    end

    // Stage-1 datapath: lane magnitudes, beat index, threshold of the last beat
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < LANES; k++) begin
                r_mag_p1[k] <= mag_sq(fft_data[k*MW +: MW]);
            end
            r_beat_p1 <= r_beat;
            if (w_last) begin
                r_thresh_p1 <= thresh;
            end
        end
    end

    // ---- stage 2: lane reduction, running max, result ----

    // Pairwise max tree across lanes; on equal values the lower lane wins
    always_comb begin
        for (int l = 0; l <= LVLS; l++) begin
            for (int k = 0; k < LANES; k++) begin
                w_tm[l][k] = '0;
                w_ti[l][k] = '0;
            end
        end
        for (int k = 0; k < LANES; k++) begin
            w_tm[0][k] = r_mag_p1[k];
            w_ti[0][k] = LW'(k);
        end
        for (int l = 0; l < LVLS; l++) begin
            for (int k = 0; k < (LANES >> (l + 1)); k++) begin
                if (w_tm[l][2*k+1] > w_tm[l][2*k]) begin
                    w_tm[l+1][k] = w_tm[l][2*k+1];
                    w_ti[l+1][k] = w_ti[l][2*k+1];
                end else begin
                    w_tm[l+1][k] = w_tm[l][2*k];
                    w_ti[l+1][k] = w_ti[l][2*k];
                end
            end
        end
    end

    assign w_beat_max = w_tm[LVLS][0];
    assign w_beat_bin = (FW'(r_beat_p1) << LVLS) | FW'(w_ti[LVLS][0]);
    // Strictly-greater keeps the earliest bin when later beats only tie
    assign w_take     = r_first_p1 || (w_beat_max > r_run_mag_p2);
    assign w_new_mag  = w_take ? w_beat_max : r_run_mag_p2;
    assign w_new_bin  = w_take ? w_beat_bin : r_run_bin_p2;
    // Once halted no further result is published, even for a beat already
    // in the pipe when the limit was reached
    assign w_fin      = r_vld_p1 && r_last_p1 && !r_halted;

    // Running maximum across the beats of the current frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_mag_p2 <= '0;
            r_run_bin_p2 <= '0;
        end else if (r_vld_p1) begin
            r_run_mag_p2 <= w_new_mag;
            r_run_bin_p2 <= w_new_bin;
        end
    end

    // Result registers, done pulse, frame counter and halt latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done   <= 1'b0;
            r_freq   <= '0;
            r_peak   <= '0;
            r_above  <= 1'b0;
            r_cnt    <= '0;
            r_halted <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_fin) begin
                r_freq  <= w_new_bin;
                r_peak  <= w_new_mag;
                r_above <= (w_new_mag >= r_thresh_p1);
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (MAX_FRAMES != 0 && (r_cnt + 1'b1) == LIMIT) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

    assign done      = r_done;
    assign freq      = r_freq;
    assign peak_mag  = r_peak;
    assign above     = r_above;
    assign frame_cnt = r_cnt;
    assign halted    = r_halted;

endmodule
